// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencing controller.
package mult_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Requester/datapath <-> controller signal bundle; master drives requests and datapath flags.
interface mult_seq_ctrl_if
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
);

    logic             start;
    logic             lsb;
    logic             mplier_zero;
    logic             load;
    logic             add_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic             K;

    modport master (
        output start, lsb, mplier_zero,
        input  load, add_en, shift_en, busy, done, cnt, K
    );

    modport slave (
        input  start, lsb, mplier_zero,
        output load, add_en, shift_en, busy, done, cnt, K
    );

endinterface

// File: rtl/mult_seq_ctrl_bit_counter.sv
// Down-counter for multiplier bit iterations; K flags the last iteration (cnt == 0).
module mult_bit_counter #(
    parameter int               CNT_W  = 3,
    parameter logic [CNT_W-1:0] RELOAD = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             K
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= RELOAD;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign K   = (r_cnt == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer: Moore FSM driving load/add/shift strobes from the multiplier LSB.
// Optional early termination on an all-zero remaining multiplier: define MULT_EARLY_TERM_EN.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_ctrl_if.slave  bus
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_ld;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_K;

    mult_bit_counter #(
        .CNT_W  (CNT_W),
        .RELOAD (RELOAD)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (w_ld),
        .dec   (w_dec),
        .cnt   (w_cnt),
        .K     (w_K)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifndef MULT_EARLY_TERM_EN
    logic w_unused_mplier_zero;
    assign w_unused_mplier_zero = bus.mplier_zero;
`endif

    always_comb begin
        w_next       = r_state;
        w_ld         = 1'b0;
        w_dec        = 1'b0;
        bus.load     = 1'b0;
        bus.add_en   = 1'b0;
        bus.shift_en = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = INIT;
            end
            INIT: begin
                bus.load = 1'b1;
                bus.busy = 1'b1;
                w_ld     = 1'b1;
                w_next   = TEST;
            end
            TEST: begin
                bus.busy = 1'b1;
`ifdef MULT_EARLY_TERM_EN
                // Zero remaining multiplier wins over lsb; counter stays frozen.
                if (bus.mplier_zero)  w_next = DONE;
                else if (bus.lsb)     w_next = ADD;
                else                  w_next = SHIFT;
`else
                w_next = bus.lsb ? ADD : SHIFT;
`endif
            end
            ADD: begin
                bus.add_en = 1'b1;
                bus.busy   = 1'b1;
                w_next     = SHIFT;
            end
            SHIFT: begin
                bus.shift_en = 1'b1;
                bus.busy     = 1'b1;
                if (w_K) begin
                    w_next = DONE;
                end else begin
                    w_dec  = 1'b1;
                    w_next = TEST;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.cnt = w_cnt;
    assign bus.K   = w_K;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural shift-add datapath.
module tb_mult_seq_ctrl;
    import mult_ctrl_pkg::*;

    localparam int W = DEF_WIDTH;
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int             c0;
        int             lat;
        int             adds;
        int             shifts;
        int             cnt_end;
        logic [2*W-1:0] prod;
        bit             chk_prod;
    } exp_t;

    typedef struct {
        logic [W-1:0] mc;
        logic [W-1:0] mp;
    } opnd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();
    mult_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t  sb[$];
    opnd_t opq[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    int    n_add = 0;
    int    n_sh = 0;
    bit    prev_add = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input int c0, input logic [W-1:0] mp, input logic [W-1:0] mc);
        exp_t e;
        int   pop = 0;
        int   h = -1;
        for (int i = 0; i < W; i++) begin
            if (mp[i]) begin
                pop++;
                h = i;
            end
        end
        e.c0   = c0;
        e.adds = pop;
        e.prod = {{W{1'b0}}, mp} * {{W{1'b0}}, mc};
        if (EARLY && h < W - 1) begin
            e.shifts   = h + 1;
            e.lat      = 3 + 2 * (h + 1) + pop;
            e.cnt_end  = W - 1 - e.shifts;
            e.chk_prod = 1'b0;
        end else begin
            e.shifts   = W;
            e.lat      = 2 + 2 * W + pop;
            e.cnt_end  = 0;
            e.chk_prod = 1'b1;
        end
        return e;
    endfunction

    // Reference datapath: product_hi accumulates, {carry,product} and multiplier shift right.
    logic [2*W:0] r_P;
    logic [W-1:0] r_M;
    logic [W-1:0] r_mc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_P  <= '0;
            r_M  <= '0;
            r_mc <= '0;
        end else begin
            if (bus.load) begin
                if (opq.size() > 0) begin
                    r_M  <= opq[0].mp;
                    r_mc <= opq[0].mc;
                    void'(opq.pop_front());
                end
                r_P <= '0;
            end
            if (bus.add_en)   r_P[2*W:W] <= r_P[2*W:W] + {1'b0, r_mc};
            if (bus.shift_en) begin
                r_P <= r_P >> 1;
                r_M <= r_M >> 1;
            end
        end
    end

    assign bus.lsb         = r_M[0];
    assign bus.mplier_zero = (r_M == '0);

    always @(negedge clk) begin : mon
        exp_t e;
        bit   in_op;
        if (rst_n) begin
            in_op = (sb.size() > 0) && (cyc >= sb[0].c0 + 1) && (cyc <= sb[0].c0 + sb[0].lat);
            check_eq("busy", bus.busy, in_op);
            if (prev_add) check_eq("add_then_shift", bus.shift_en, 1);
            prev_add = bus.add_en;
            if (bus.load) begin
                if (sb.size() == 0) check_eq("spurious_load", bus.load, 0);
                else                check_eq("load_cycle", cyc, sb[0].c0 + 1);
                n_add = 0;
                n_sh  = 0;
            end
            if (bus.add_en) n_add++;
            if (bus.shift_en) begin
                check_eq("cnt_at_shift", bus.cnt, W - 1 - n_sh);
                n_sh++;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_cycle", cyc, e.c0 + e.lat);
                    check_eq("add_count", n_add, e.adds);
                    check_eq("shift_count", n_sh, e.shifts);
                    check_eq("cnt_at_done", bus.cnt, e.cnt_end);
                    check_eq("K_at_done", bus.K, e.cnt_end == 0);
                    if (e.chk_prod) check_eq("product", r_P[2*W-1:0], e.prod);
                end
            end
        end else begin
            prev_add = 1'b0;
        end
    end

    task automatic check_reset_outputs();
        check_eq("rst_load", bus.load, 0);
        check_eq("rst_add_en", bus.add_en, 0);
        check_eq("rst_shift_en", bus.shift_en, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_cnt", bus.cnt, 0);
        check_eq("rst_K", bus.K, 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (sb.size() > 0) begin
            check_eq("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Asserts start for one cycle in the next (idle) cycle; that cycle is cycle 0.
    task automatic issue(input logic [W-1:0] a_mp, input logic [W-1:0] a_mc);
        opnd_t o;
        @(negedge clk);
        #2;
        o.mc = a_mc;
        o.mp = a_mp;
        opq.push_back(o);
        sb.push_back(make_exp(cyc, a_mp, a_mc));
        bus.start = 1'b1;
        @(negedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a_mp, input logic [W-1:0] a_mc);
        issue(a_mp, a_mc);
        wait_drain(100);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int    c0;
        int    k;
        exp_t  e1;
        exp_t  e2;
        opnd_t o;

        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #2 rst_n = 1'b1;

        run_op(8'h00, 8'hA7);
        run_op(8'h05, 8'h3C);
        run_op(8'hFF, 8'hFF);
        run_op(8'h81, 8'h55);
        run_op(8'h40, 8'hC3);

        // start pulses while busy must be ignored
        issue(8'h5A, 8'h13);
        repeat (4) @(negedge clk);
        #2 bus.start = 1'b1;
        repeat (3) @(negedge clk);
        #2 bus.start = 1'b0;
        wait_drain(100);

        // start held high: accepted at cycle 0 and again in the idle cycle after DONE
        @(negedge clk);
        #2;
        c0 = cyc;
        e1 = make_exp(c0, 8'h03, 8'h21);
        e2 = make_exp(c0 + e1.lat + 1, 8'hC4, 8'h0F);
        o.mp = 8'h03; o.mc = 8'h21; opq.push_back(o);
        o.mp = 8'hC4; o.mc = 8'h0F; opq.push_back(o);
        sb.push_back(e1);
        sb.push_back(e2);
        bus.start = 1'b1;
        k = 0;
        while (cyc < e2.c0 + 1 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        bus.start = 1'b0;
        wait_drain(100);

        // asynchronous reset in cycle 9 of a 0xFF multiply aborts without done
        issue(8'hFF, 8'h99);
        c0 = sb[sb.size()-1].c0;
        while (cyc < c0 + 9) begin
            @(negedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        opq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run_op(8'hFF, 8'h99);

        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
